// File: rtl/uart_rx_os16_pkg.sv
// Shared types, constants and helpers for the 16x-oversampling UART receiver.
package uart_rx_os16_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } rx_state_e;

  localparam int unsigned LenMin     = 5;
  localparam int unsigned LenMax     = 8;
  localparam logic        ParEven    = 1'b0;
  localparam logic        ParOdd     = 1'b1;
  localparam logic [3:0]  SampleMid  = 4'd7;
  localparam logic [3:0]  SampleLast = 4'd15;

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if (len < 4'(LenMin)) return 4'(LenMin);
    if (len > 4'(LenMax)) return 4'(LenMax);
    return len;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// Receive-side holding register handshake between the UART receiver and its consumer.
interface uart_rx_os16_if;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_parity_err_o;
  logic       rx_frame_err_o;
  logic       rx_break_o;
  logic       rx_overrun_o;
  logic       rx_ready_i;
  logic       ovr_clr_i;

  modport master (
    output rx_data_o, rx_valid_o, rx_parity_err_o, rx_frame_err_o, rx_break_o, rx_overrun_o,
    input  rx_ready_i, ovr_clr_i
  );

  modport slave (
    input  rx_data_o, rx_valid_o, rx_parity_err_o, rx_frame_err_o, rx_break_o, rx_overrun_o,
    output rx_ready_i, ovr_clr_i
  );
endinterface

// File: rtl/uart_rx_os16_baud_tick.sv
// Oversample tick generator: one-cycle pulse every max(div_i,1) clocks, restartable.
module uart_rx_os16_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] cnt_d, cnt_q;
  logic             wrap;

  always_comb begin
    div_eff = (div_i == '0) ? DIV_W'(1) : div_i;
    // >= keeps the counter bounded if the divisor shrinks mid-count
    wrap    = (cnt_q >= div_eff - DIV_W'(1));
    tick_o  = wrap;
    if (restart_i) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// 16x-oversampling UART receiver with majority vote, error flags and a one-entry holding register.
module uart_rx_os16
  import uart_rx_os16_pkg::*;
#(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_i,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic [3:0]       length_i,
  input  logic             parity_en_i,
  input  logic             parity_type_i,
  input  logic             stop2_i,
  output logic             rx_busy_o,
  uart_rx_os16_if.master   rx_if
);

  logic [SYNC_STAGES-1:0] sync_d, sync_q;
  logic                   rx_s, tick, start, done, vote;
  logic                   armed_d, armed_q;
  rx_state_e              state_d, state_q;
  logic [3:0]             samp_d, samp_q, len_d, len_q;
  logic [2:0]             bit_d, bit_q;
  logic                   s7_d, s7_q, s8_d, s8_q;
  logic [7:0]             data_d, data_q;
  logic                   par_err_d, par_err_q, frm_err_d, frm_err_q;
  logic                   par_en_d, par_en_q, par_odd_d, par_odd_q, stop2_d, stop2_q;
  logic                   load;
  logic [7:0]             hold_data_d, hold_data_q;
  logic                   valid_d, valid_q, hpe_d, hpe_q, hfe_d, hfe_q, hbrk_d, hbrk_q;
  logic                   ovr_d, ovr_q;

  uart_rx_os16_baud_tick #(
    .DIV_W(DIV_W)
  ) u_baud_tick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .restart_i(start),
    .div_i    (baud_div_i),
    .tick_o   (tick)
  );

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], rx_i};
    armed_d   = armed_q | rx_s;
    state_d   = state_q;
    samp_d    = samp_q;
    bit_d     = bit_q;
    s7_d      = s7_q;
    s8_d      = s8_q;
    data_d    = data_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    len_d     = len_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    stop2_d   = stop2_q;
    start     = 1'b0;
    done      = 1'b0;
    vote      = maj3(s7_q, s8_q, rx_s);

    if (state_q != StIdle && tick) begin
      samp_d = samp_q + 4'd1;
      if (samp_q == SampleMid)         s7_d = rx_s;
      if (samp_q == SampleMid + 4'd1)  s8_d = rx_s;
    end

    unique case (state_q)
      StIdle: begin
        if (armed_q && !rx_s) begin
          start     = 1'b1;
          state_d   = StStart;
          samp_d    = '0;
          bit_d     = '0;
          data_d    = '0;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
          len_d     = clamp_len(length_i);
          par_en_d  = parity_en_i;
          par_odd_d = parity_type_i;
          stop2_d   = stop2_i;
        end
      end
      StStart: begin
        if (tick && samp_q == SampleMid && rx_s) begin
          state_d = StIdle;
        end else if (tick && samp_q == SampleLast) begin
          state_d = StData;
        end
      end
      StData: begin
        if (tick && samp_q == SampleMid + 4'd2) data_d[bit_q] = vote;
        if (tick && samp_q == SampleLast) begin
          bit_d = bit_q + 3'd1;
          if ({1'b0, bit_q} == len_q - 4'd1) state_d = par_en_q ? StParity : StStop1;
        end
      end
      StParity: begin
        if (tick && samp_q == SampleMid + 4'd2) par_err_d = ((^data_q) ^ vote) != par_odd_q;
        if (tick && samp_q == SampleLast) state_d = StStop1;
      end
      StStop1: begin
        if (tick && samp_q == SampleMid + 4'd2) begin
          if (!vote) frm_err_d = 1'b1;
          if (!stop2_q) begin
            done    = 1'b1;
            state_d = StIdle;
          end
        end
        if (tick && samp_q == SampleLast && stop2_q) state_d = StStop2;
      end
      StStop2: begin
        if (tick && samp_q == SampleMid + 4'd2) begin
          if (!vote) frm_err_d = 1'b1;
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A completion while the old char is still unconsumed is dropped and flagged.
  always_comb begin
    load        = done && (!valid_q || rx_if.rx_ready_i);
    valid_d     = load | (valid_q & ~rx_if.rx_ready_i);
    hold_data_d = hold_data_q;
    hpe_d       = hpe_q;
    hfe_d       = hfe_q;
    hbrk_d      = hbrk_q;
    if (load) begin
      hold_data_d = data_q;
      hpe_d       = par_err_d;
      hfe_d       = frm_err_d;
      hbrk_d      = frm_err_d && (data_q == '0);
    end
    ovr_d = (done & valid_q & ~rx_if.rx_ready_i) | (ovr_q & ~rx_if.ovr_clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sync_q      <= '0;
      armed_q     <= 1'b0;
      state_q     <= StIdle;
      samp_q      <= '0;
      bit_q       <= '0;
      s7_q        <= 1'b0;
      s8_q        <= 1'b0;
      data_q      <= '0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      len_q       <= '0;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      stop2_q     <= 1'b0;
      hold_data_q <= '0;
      valid_q     <= 1'b0;
      hpe_q       <= 1'b0;
      hfe_q       <= 1'b0;
      hbrk_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      samp_q      <= samp_d;
      bit_q       <= bit_d;
      s7_q        <= s7_d;
      s8_q        <= s8_d;
      data_q      <= data_d;
      par_err_q   <= par_err_d;
      frm_err_q   <= frm_err_d;
      len_q       <= len_d;
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      stop2_q     <= stop2_d;
      hold_data_q <= hold_data_d;
      valid_q     <= valid_d;
      hpe_q       <= hpe_d;
      hfe_q       <= hfe_d;
      hbrk_q      <= hbrk_d;
      ovr_q       <= ovr_d;
    end
  end

  assign rx_busy_o             = (state_q != StIdle);
  assign rx_if.rx_data_o       = hold_data_q;
  assign rx_if.rx_valid_o      = valid_q;
  assign rx_if.rx_parity_err_o = hpe_q;
  assign rx_if.rx_frame_err_o  = hfe_q;
  assign rx_if.rx_break_o      = hbrk_q;
  assign rx_if.rx_overrun_o    = ovr_q;

endmodule
